// File: rtl/stallable_pipeline_n_if.sv
// Handshake bundle between producer, pipeline and consumer (valid/allowin protocol).
// Carries upstream data/valid, downstream allow, per-stage stalls, flush and status outputs.
// WIDTH/DEPTH must match the parameters of the pipeline instance bound to it.
interface stallable_pipeline_n_if #(
  parameter int WIDTH = 100,
  parameter int DEPTH = 3
);
  localparam int OCC_W = $clog2(DEPTH + 1);

  logic             validin;
  logic [WIDTH-1:0] datain;
  logic             in_allow;
  logic [DEPTH-1:0] stage_stall;
  logic             flush;
  logic             out_allow;
  logic             validout;
  logic [WIDTH-1:0] dataout;
  logic [OCC_W-1:0] occupancy;
  logic [31:0]      stat_backpressure;

  // Producer/consumer side: drives data in, allow out, stalls and flush.
  modport master (
    output validin, datain, stage_stall, flush, out_allow,
    input  in_allow, validout, dataout, occupancy, stat_backpressure
  );

  // Pipeline side.
  modport slave (
    input  validin, datain, stage_stall, flush, out_allow,
    output in_allow, validout, dataout, occupancy, stat_backpressure
  );
endinterface

// File: rtl/stallable_pipeline_n.sv
// Purpose: DEPTH-stage valid/allowin pipeline with per-stage stalls, flush and occupancy count.
// Latency: DEPTH cycles register residency (accept at edge n -> validout after edge n+DEPTH-1).
// Backpressure: allowin chain is combinational end to end; a full pipe with out_allow=0 holds.
// Optional backpressure statistics counter enabled by defining STALLABLE_PIPELINE_STATS_EN.
module stallable_pipeline_n #(
  parameter int WIDTH = 100,
  parameter int DEPTH = 3,
  localparam int OCC_W = $clog2(DEPTH + 1)
) (
  input logic                  clk,
  input logic                  rst,
  stallable_pipeline_n_if.slave bus
);

  logic [DEPTH-1:0] valid_vec;
  logic [OCC_W-1:0] occ;
  logic             validout;

  for (genvar k = 0; k < DEPTH; k++) begin : g_stage
    logic             ready_go;
    logic             allowin;
    logic             next_allow;
    logic             src_valid;
    logic             to_next_valid;
    logic [WIDTH-1:0] src_data;
    logic             valid_q;
    logic             valid_d;
    logic [WIDTH-1:0] data_q;
    logic [WIDTH-1:0] data_d;

    assign ready_go      = !bus.stage_stall[k];
    assign allowin       = !valid_q || (ready_go && next_allow);
    assign to_next_valid = valid_q && ready_go;

    // The last stage looks at the consumer; every other stage at its successor.
    if (k == DEPTH - 1) begin : g_last
      assign next_allow = bus.out_allow;
    end else begin : g_mid
      assign next_allow = g_stage[k+1].allowin;
    end

    // Stage 0 is fed by the producer, later stages by their predecessor.
    if (k == 0) begin : g_src_in
      assign src_valid = bus.validin;
      assign src_data  = bus.datain;
    end else begin : g_src_prev
      assign src_valid = g_stage[k-1].to_next_valid;
      assign src_data  = g_stage[k-1].data_q;
    end

    // Next-state: take new valid when allowed, capture data only on a real transfer;
    // flush kills every entry regardless of stalls or transfers.
    always_comb begin
      valid_d = valid_q;
      data_d  = data_q;
      if (allowin) begin
        valid_d = src_valid;
      end
      if (src_valid && allowin) begin
        data_d = src_data;
      end
      if (bus.flush) begin
        valid_d = 1'b0;
      end
    end

    // Stage registers; reset discards everything in flight.
    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        valid_q <= 1'b0;
        data_q  <= '0;
      end else begin
        valid_q <= valid_d;
        data_q  <= data_d;
      end
    end

    assign valid_vec[k] = valid_q;
  end

  // Occupancy is simply the population count of the stage valid bits.
  always_comb begin
    occ = '0;
    for (int i = 0; i < DEPTH; i++) begin
      occ = occ + OCC_W'(valid_vec[i]);
    end
  end

  assign validout      = g_stage[DEPTH-1].to_next_valid;
  assign bus.validout  = validout;
  assign bus.dataout   = g_stage[DEPTH-1].data_q;
  assign bus.in_allow  = g_stage[0].allowin && !bus.flush;
  assign bus.occupancy = occ;

`ifdef STALLABLE_PIPELINE_STATS_EN
  logic [31:0] bp_cnt_q;
  logic [31:0] bp_cnt_d;

  // Count cycles where the consumer refuses presented data; saturate at all-ones.
  always_comb begin
    bp_cnt_d = bp_cnt_q;
    if (validout && !bus.out_allow && (bp_cnt_q != 32'hFFFF_FFFF)) begin
      bp_cnt_d = bp_cnt_q + 32'd1;
    end
  end

  // Counter register; only reset clears it, flush leaves it alone.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      bp_cnt_q <= 32'd0;
    end else begin
      bp_cnt_q <= bp_cnt_d;
    end
  end

  assign bus.stat_backpressure = bp_cnt_q;
`else
  assign bus.stat_backpressure = 32'd0;
`endif

endmodule

// File: doc/stallable_pipeline_n.md
Name: stallable_pipeline_n

Overview:
- Parametrised successor to the fixed 3-stage valid/allowin stallable pipeline.
- DEPTH and WIDTH are configurable.
- Adds per-stage stall inputs, a synchronous flush, an upstream allowin output and an occupancy count.
- Used as a generic datapath delay/buffer between a producer and a consumer that both use the valid/allowin handshake (e.g. the pipelined adder datapath).

Parameters:
WIDTH  100  data bits per stage
DEPTH  3  number of pipeline stages; legal range 1..16
OCC_W  $clog2(DEPTH+1)  occupancy width; derived, do not override

Ports:
clk  input  1  clock, rising edge
rst  input  1  asynchronous active-low reset
validin  input  1  upstream data valid
datain  input  WIDTH  upstream data
in_allow  output  1  stage 0 can accept this cycle
stage_stall  input  DEPTH  bit k high: stage k not ready_go this cycle
flush  input  1  synchronous kill of all in-flight entries
out_allow  input  1  downstream accepts
validout  output  1  last stage presents valid data
dataout  output  WIDTH  last stage data
occupancy  output  OCC_W  number of valid stages, combinational from the valid regs
stat_backpressure  output  32  backpressure counter (see Optional Feature)

Behaviour:
- Per stage k (0..DEPTH-1): registers valid_k and data_k.
  - ready_go_k = !stage_stall[k]
  - allowin_k = !valid_k || (ready_go_k && next_allow_k)
  - next_allow_k = allowin_{k+1} for k < DEPTH-1; out_allow for the last stage
  - to_next_valid_k = valid_k && ready_go_k
- Stage 0 source: validin/datain. Stage k>0 source: to_next_valid_{k-1} / data_{k-1}.
- Updates at posedge:
  - if allowin_k: valid_k <= source valid
  - if source valid && allowin_k: data_k <= source data
  - data_k is held otherwise
- Outputs:
  - in_allow = allowin_0 && !flush
  - validout = valid_{DEPTH-1} && ready_go_{DEPTH-1}
  - dataout = data_{DEPTH-1}, always driven, meaningful only when validout is high
- Async reset (rst low): all valid_k = 0 and data_k = 0 immediately.
  - Outputs during reset: in_allow=1, validout=0, dataout=0, occupancy=0, stat_backpressure=0.
  - Reset mid-stream discards all entries; there is no drain.
- Latency: an item accepted at edge n appears on validout after edge n+DEPTH-1 (DEPTH cycles of register residency) when nothing stalls. Throughput is 1 item/cycle.
- Stall on an empty stage has no effect; the bubble is still absorbed (allowin_k=1 because valid_k=0).
- A stall on stage k back-pressures stages 0..k only once they are all full; bubbles upstream of k keep filling.
- out_allow=0 with full pipe:
  - in_allow=0 and every register holds.
  - validout stays high and dataout stays stable until out_allow=1.
- Simultaneous handshake: the last stage accepts new data on the same edge it is consumed (the allowin chain is combinational and goes full-depth). No dead cycle.
- flush=1 at an edge:
  - all valid_k <= 0; overrides any transfer and any stall.
  - validin during a flush cycle is dropped; in_allow is 0 then, so no handshake completes.
  - validout may still be high during the flush cycle. The consumer must ignore it when flush is high; the item is killed, not delivered.
- occupancy: counts valid_k bits; range 0..DEPTH.
- DEPTH=1 degenerates to a single-register slice with identical rules.

Optional Feature:
- Macro: STALLABLE_PIPELINE_STATS_EN.
- Defined:
  - stat_backpressure is a 32-bit saturating counter, incremented each cycle validout=1 && out_allow=0.
  - Cleared by rst only, not by flush.
  - Holds at 32'hFFFF_FFFF.
- Undefined: stat_backpressure tied to 0; no counter logic is synthesised.

Test Plan:
1. DEPTH=3, WIDTH=8, no stalls, out_allow=1. Feed 0x01..0x05 on consecutive cycles -> validout first high 3 cycles after first accept; dataout 0x01..0x05 back-to-back; occupancy peaks at 3.
2. Fill with 0xA1,0xA2,0xA3, then out_allow=0 for 4 cycles -> in_allow=0; dataout holds 0xA1; occupancy=3. With STATS_EN, stat_backpressure=4. Release -> 0xA1,0xA2,0xA3 in order, no duplicates or losses.
3. stage_stall=3'b010 for 2 cycles while streaming 0x10,0x11,0x12,... -> stage 0 fills behind stage 1 and in_allow drops. After release, output order is preserved; total latency of 0x10 = 3+2 cycles.
4. Pipe holding 3 items, flush=1 for one cycle with validin=1, datain=0x55 -> next cycle occupancy=0, validout=0; 0x55 is never output.
5. Assert rst low asynchronously mid-cycle with 2 items in flight -> validout=0 and dataout=0 before the next edge; after release, the pipe resumes with a new item 0x77 and latency 3.
6. DEPTH=1, WIDTH=100: alternate out_allow 1/0 every cycle while validin=1 -> exactly one transfer per out_allow=1 cycle; in_allow tracks out_allow when full.
